key_display_ctrl: RTL

Consumer side of the keypad scanner's output handshake. It accepts the one-cycle `valid_key` strobe with its 4-bit `digit` and keeps a two-digit history: the newest key is shown on the right and the previous key on the left. It time-multiplexes the dual common-anode seven-segment display through a four-state refresh FSM, with a blanking interval between digits to suppress ghosting. It sits between `keypad_fsm` and the board display pins.

---
 rtl/key_display_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/key_display_ctrl.sv
// key_display_ctrl
//   Takes keys from the keypad scanner's one-cycle valid_key handshake and
//   keeps a two-digit history (newest on the right, previous on the left).
//   Drives a dual common-anode seven-segment display by time-multiplexing
//   the two digits. A dark interval between the digits suppresses ghosting.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   digit[3:0]   in   hex value of the key; only sampled on a capture cycle
//   valid_key    in   key-accepted strobe; a rising edge captures digit
//   seg[6:0]     out  segments {g,f,e,d,c,b,a}, active-low
//   an[1:0]      out  anode enables, active-low (an[1] left, an[0] right)
//   left_digit   out  older stored key (debug)
//   right_digit  out  newest stored key (debug)
module key_display_ctrl #(
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       valid_key,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] left_digit,
  output logic [3:0] right_digit
);

  localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK_L = 2'd0,
    SHOW_L  = 2'd1,
    BLANK_R = 2'd2,
    SHOW_R  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_last;
  logic            valid_prev;
  logic            capture;
  logic [3:0]      left_nxt, right_nxt;
  logic [6:0]      seg_nxt;
  logic [1:0]      an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    // Only a rising edge of the strobe captures, so a held strobe shifts once.
    capture   = valid_key & ~valid_prev;
    left_nxt  = capture ? right_digit : left_digit;
    right_nxt = capture ? digit       : right_digit;

    cnt_last  = (state == SHOW_L || state == SHOW_R) ? SHOW_LAST : BLANK_LAST;
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    if (cnt == cnt_last) begin
      cnt_nxt = '0;
      case (state)
        BLANK_L: state_nxt = SHOW_L;
        SHOW_L:  state_nxt = BLANK_R;
        BLANK_R: state_nxt = SHOW_R;
        default: state_nxt = BLANK_L;
      endcase
    end

    // Outputs are registered from the next state and next digits, so they
    // behave exactly like a Moore decode of the registers (a capture during
    // SHOW is visible the cycle after its edge) while coming from flops.
    an_nxt  = 2'b11;
    seg_nxt = 7'h7F;
    case (state_nxt)
      SHOW_L: begin an_nxt = 2'b01; seg_nxt = hex7(left_nxt);  end
      SHOW_R: begin an_nxt = 2'b10; seg_nxt = hex7(right_nxt); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK_L;
      cnt         <= '0;
      left_digit  <= 4'h0;
      right_digit <= 4'h0;
      // Starting "high" means a strobe held across reset release is ignored.
      valid_prev  <= 1'b1;
      an          <= 2'b11;
      seg         <= 7'h7F;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      left_digit  <= left_nxt;
      right_digit <= right_nxt;
      valid_prev  <= valid_key;
      an          <= an_nxt;
      seg         <= seg_nxt;
    end
  end

endmodule
